// File: rtl/keys_debouncer.sv
// -----------------------------------------------------------------------------
// keys_debouncer
//
// Per-key debouncer for the keyboard matrix front end. Each of NUM_KEYS raw,
// asynchronous switch levels passes through a 2-flop synchronizer and a
// stability counter. The clean level only moves to the synchronized level
// after it has differed from the current clean level for 2^CNT_WIDTH
// consecutive clock cycles. Any return to the clean level restarts the count,
// so bounce shorter than the window never reaches the output.
//
// Parameters:
//   NUM_KEYS  - number of independent key channels
//   CNT_WIDTH - counter width; stability window = 2^CNT_WIDTH clk_i cycles
//
// Ports:
//   clk_i    in   1         debounce clock (~128 kHz), rising-edge active
//   rst_n_i  in   1         asynchronous active-low reset
//   keys_i   in   NUM_KEYS  raw key levels, bit n = key n
//   keys_o   out  NUM_KEYS  debounced key levels, same polarity, registered
// -----------------------------------------------------------------------------
module keys_debouncer #(
    parameter int NUM_KEYS  = 61,
    parameter int CNT_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic [NUM_KEYS-1:0] keys_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    // Terminal count: the last mismatching cycle before the output is allowed to move.
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic [NUM_KEYS-1:0]                sync1_q;
    logic [NUM_KEYS-1:0]                sync2_q;
    logic [NUM_KEYS-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [NUM_KEYS-1:0][CNT_WIDTH-1:0] cnt_d;
    logic [NUM_KEYS-1:0]                out_q;
    logic [NUM_KEYS-1:0]                out_d;

    // Two-stage synchronizer bringing the asynchronous key levels into clk_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= {NUM_KEYS{1'b0}};
            sync2_q <= {NUM_KEYS{1'b0}};
        end else begin
            sync1_q <= keys_i;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel stability counter and output update rule.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        for (int n = 0; n < NUM_KEYS; n++) begin
            if (sync2_q[n] == out_q[n]) begin
                // Level agrees with the clean output: any partial count is bounce.
                cnt_d[n] = CNT_ZERO;
                out_d[n] = out_q[n];
            end else if (cnt_q[n] != CNT_MAX) begin
                cnt_d[n] = cnt_q[n] + CNT_ONE;
                out_d[n] = out_q[n];
            end else begin
                // Mismatch has persisted for the full window: accept the new level.
                cnt_d[n] = CNT_ZERO;
                out_d[n] = sync2_q[n];
            end
        end
    end

    // Counter and clean-output state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= {(NUM_KEYS*CNT_WIDTH){1'b0}};
            out_q <= {NUM_KEYS{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign keys_o = out_q;

endmodule

// File: tb/tb_keys_debouncer.sv
// -----------------------------------------------------------------------------
// tb_keys_debouncer
//
// Directed, self-checking bench for keys_debouncer (NUM_KEYS = 61,
// CNT_WIDTH = 8, window = 256 cycles, press-to-output latency = 258 edges).
// Outputs are sampled 1 time unit after each rising edge; inputs are driven
// at the same point, well before the next edge.
// -----------------------------------------------------------------------------
module tb_keys_debouncer;

    localparam int NK = 61;

    logic          clk_i;
    logic          rst_n_i;
    logic [NK-1:0] keys_i;
    logic [NK-1:0] keys_o;
    logic [NK-1:0] exp_v;

    int n_cmp;
    int n_err;

    keys_debouncer #(
        .NUM_KEYS  (NK),
        .CNT_WIDTH (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .keys_i  (keys_i),
        .keys_o  (keys_o)
    );

    // Free-running debounce clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Advance n rising edges, then settle just past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n_i = 1'b0;
        keys_i  = {NK{1'b1}};
        exp_v   = {NK{1'b0}};

        // Reset with all keys held high.
        #1;
        check("reset_immediate", keys_o, {NK{1'b0}});
        tick(5);
        check("reset_held", keys_o, {NK{1'b0}});
        rst_n_i = 1'b1;
        tick(257);
        check("startup_e257", keys_o, {NK{1'b0}});
        tick(1);
        check("startup_e258", keys_o, {NK{1'b1}});

        // Release everything to reach a steady all-zero state.
        keys_i = {NK{1'b0}};
        tick(257);
        check("release_all_e257", keys_o, {NK{1'b1}});
        tick(1);
        check("release_all_e258", keys_o, {NK{1'b0}});

        // Single press on key 0.
        keys_i[0] = 1'b1;
        tick(257);
        check("press0_e257", keys_o, exp_v);
        tick(1);
        exp_v[0] = 1'b1;
        check("press0_e258", keys_o, exp_v);

        // Glitch of 255 cycles on key 5 is rejected.
        keys_i[5] = 1'b1;
        tick(255);
        check("glitch5_during", keys_o, exp_v);
        keys_i[5] = 1'b0;
        tick(3);
        check("glitch5_after_window", keys_o, exp_v);
        tick(300);
        check("glitch5_settled", keys_o, exp_v);

        // A 256-cycle pulse on key 6 is just long enough to pass.
        keys_i[6] = 1'b1;
        tick(256);
        keys_i[6] = 1'b0;
        tick(1);
        check("pulse6_e257", keys_o, exp_v);
        tick(1);
        exp_v[6] = 1'b1;
        check("pulse6_e258", keys_o, exp_v);
        tick(300);
        exp_v[6] = 1'b0;
        check("pulse6_released", keys_o, exp_v);

        // Bounce on key 10: toggle every 20 cycles for 1000 cycles, then hold high.
        for (int seg = 0; seg < 50; seg++) begin
            keys_i[10] = (seg % 2 == 0) ? 1'b1 : 1'b0;
            tick(20);
            check("bounce10_segment", keys_o, exp_v);
        end
        keys_i[10] = 1'b1;
        tick(257);
        check("bounce10_e257", keys_o, exp_v);
        tick(1);
        exp_v[10] = 1'b1;
        check("bounce10_e258", keys_o, exp_v);

        // Bring key 60 high, then release it while pressing key 1 on the same cycle.
        keys_i[60] = 1'b1;
        tick(258);
        exp_v[60] = 1'b1;
        check("press60_e258", keys_o, exp_v);
        keys_i[60] = 1'b0;
        keys_i[1]  = 1'b1;
        tick(257);
        check("swap_60_1_e257", keys_o, exp_v);
        tick(1);
        exp_v[60] = 1'b0;
        exp_v[1]  = 1'b1;
        check("swap_60_1_e258", keys_o, exp_v);

        // Asynchronous reset in the middle of a count on key 3.
        keys_i[3] = 1'b1;
        tick(102);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midcount_reset_immediate", keys_o, {NK{1'b0}});
        tick(3);
        check("midcount_reset_held", keys_o, {NK{1'b0}});
        rst_n_i = 1'b1;
        tick(257);
        check("midcount_restart_e257", keys_o, {NK{1'b0}});
        tick(1);
        exp_v    = {NK{1'b0}};
        exp_v[0] = 1'b1;
        exp_v[1] = 1'b1;
        exp_v[3] = 1'b1;
        exp_v[10] = 1'b1;
        check("midcount_restart_e258", keys_o, exp_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
